// File: rtl/enc_frame_serializer.sv
// Byte-to-2-bit symbol serializer with XOR encryption, aligned to the upstream Cnt4 phase.
// Optional build macro ROTATE_KEY_EN enables the internal rotating key register.
module enc_frame_serializer (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] Cnt4,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic [7:0] key,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] out_bits,
   output logic       out_last
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_ALIGN = 2'd1,
      SHIFT      = 2'd2
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] shift_reg;
   logic [1:0] sym_cnt;
   logic [7:0] cur_key;
   logic       accept;

   // A new byte can only enter when nothing is in flight or the last symbol is on the wire.
   assign in_ready = (state == IDLE) || ((state == SHIFT) && (sym_cnt == 2'd3));
   assign accept   = in_valid && in_ready;

`ifdef ROTATE_KEY_EN
   logic [7:0] key_reg;
   logic       key_loaded;

   // The first accept after reset uses the key port; every later accept uses the rotated copy.
   assign cur_key = key_loaded ? key_reg : key;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_reg    <= 8'h00;
         key_loaded <= 1'b0;
      end else if (accept) begin
         key_reg    <= {cur_key[5:0], cur_key[7:6]};
         key_loaded <= 1'b1;
      end
   end
`else
   assign cur_key = key;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= 8'h00;
         sym_cnt   <= 2'd0;
      end else if (accept) begin
         shift_reg <= in_data ^ cur_key;
         sym_cnt   <= 2'd0;
      end else if (state == SHIFT) begin
         sym_cnt <= sym_cnt + 2'd1;
      end
   end

   // Leaving WAIT_ALIGN on the Cnt4=3 edge puts the first symbol in the Cnt4=0 cycle.
   always_comb begin
      next_state = state;
      out_valid  = 1'b0;
      out_bits   = 2'b00;
      out_last   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (Cnt4 == 2'd3) ? SHIFT : WAIT_ALIGN;
            end
         end
         WAIT_ALIGN: begin
            if (Cnt4 == 2'd3) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            out_valid = 1'b1;
            case (sym_cnt)
               2'd0:    out_bits = shift_reg[7:6];
               2'd1:    out_bits = shift_reg[5:4];
               2'd2:    out_bits = shift_reg[3:2];
               default: out_bits = shift_reg[1:0];
            endcase
            if (sym_cnt == 2'd3) begin
               out_last   = 1'b1;
               next_state = accept ? SHIFT : IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule
